// File: rtl/alu_exec_ctrl_if.sv
// Instruction and direct-load bus between an instruction source and alu_exec_ctrl.
// The source drives instructions and loads, and the controller answers with instr_ready.
interface alu_exec_ctrl_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [2:0] instr_rd;
    logic [2:0] instr_ra;
    logic [2:0] instr_rb;
    logic       ld_valid;
    logic [2:0] ld_addr;
    logic [3:0] ld_data;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
        output ld_valid, ld_addr, ld_data,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
        input  ld_valid, ld_addr, ld_data,
        output instr_ready
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Four-state execution controller around an external 4-bit ALU.
// It owns an 8x4 register file and a Z/C/S status register.
module alu_exec_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    alu_exec_ctrl_if.slave        bus,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic [1:0]            alu_op,
    output logic                  alu_l,
    input  logic [3:0]            alu_r,
    input  logic                  alu_zero,
    input  logic                  alu_carry,
    input  logic                  alu_sign,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_s,
    output logic                  done,
    input  logic [2:0]            dbg_addr,
    output logic [3:0]            dbg_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t     state_q, state_d;
    logic [3:0] rf [8];
    logic [2:0] rd_q, ra_q, rb_q;
    logic [3:0] res;
    logic       zc, cc, sc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.instr_ready = 1'b0;
        done            = 1'b0;
        case (state_q)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) state_d = READ;
            end
            READ: state_d = EXEC;
            EXEC: state_d = WB;
            WB: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
            rd_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            alu_l  <= 1'b0;
            res    <= '0;
            zc     <= 1'b0;
            cc     <= 1'b0;
            sc     <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_s <= 1'b0;
        end else begin
            case (state_q)
                // IDLE: accept loads and instructions; a same-cycle load lands before READ
                IDLE: begin
                    if (bus.ld_valid) rf[bus.ld_addr] <= bus.ld_data;
                    if (bus.instr_valid) begin
                        rd_q   <= bus.instr_rd;
                        ra_q   <= bus.instr_ra;
                        rb_q   <= bus.instr_rb;
                        alu_op <= bus.instr_op[1:0];
                        alu_l  <= bus.instr_op[2];
                    end
                end
                // READ: present operands to the ALU
                READ: begin
                    alu_a <= rf[ra_q];
                    alu_b <= rf[rb_q];
                end
                // EXEC: ALU has settled, capture result and flags untouched
                EXEC: begin
                    res <= alu_r;
                    zc  <= alu_zero;
                    cc  <= alu_carry;
                    sc  <= alu_sign;
                end
                // WB: commit result and status together
                WB: begin
                    rf[rd_q] <= res;
                    flag_z   <= zc;
                    flag_c   <= cc;
                    flag_s   <= sc;
                end
                default: ;
            endcase
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU stand-in, directed and random instructions
// checked against an arithmetic reference model of the register file and flags.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] alu_a, alu_b, alu_r;
    logic [1:0] alu_op;
    logic       alu_l, alu_zero, alu_carry, alu_sign;
    logic       flag_z, flag_c, flag_s, done;
    logic [2:0] dbg_addr;
    logic [3:0] dbg_data;

    always #10 clk = ~clk;

    alu_exec_ctrl_if bus ();

    alu_exec_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_l     (alu_l),
        .alu_r     (alu_r),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .alu_sign  (alu_sign),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_s    (flag_s),
        .done      (done),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // ALU stand-in: arithmetic on l=0 (neg, inc, add, sub), logic on l=1
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum = 5'd0;
        case ({alu_l, alu_op})
            3'b000:  alu_sum = {1'b0, ~alu_a} + 5'd1;
            3'b001:  alu_sum = {1'b0, alu_a} + 5'd1;
            3'b010:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            3'b011:  alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
            3'b100:  alu_sum = {1'b0, alu_a & alu_b};
            3'b101:  alu_sum = {1'b0, alu_a | alu_b};
            3'b110:  alu_sum = {1'b0, alu_a ^ alu_b};
            default: alu_sum = {1'b0, ~alu_a};
        endcase
        alu_r     = alu_sum[3:0];
        alu_carry = alu_sum[4];
        alu_zero  = (alu_sum[3:0] == 4'd0);
        alu_sign  = alu_sum[3];
    end

    int         checks = 0;
    int         errors = 0;
    logic [3:0] ref_rf [8];
    logic       ref_z, ref_c, ref_s;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {carry, result} from plain integer arithmetic.
    function automatic logic [4:0] ref_exec(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int   ia, ib, r;
        logic c;
        ia = int'(a);
        ib = int'(b);
        c  = 1'b0;
        case (op)
            3'd0:    begin r = (16 - ia) % 16;   c = (ia == 0);      end
            3'd1:    begin r = (ia + 1) % 16;    c = (ia == 15);     end
            3'd2:    begin r = (ia + ib) % 16;   c = (ia + ib > 15); end
            3'd3:    begin r = (ia - ib + 16) % 16; c = (ia >= ib);  end
            3'd4:    r = ia & ib;
            3'd5:    r = ia | ib;
            3'd6:    r = ia ^ ib;
            default: r = 15 - ia;
        endcase
        return {c, r[3:0]};
    endfunction

    task automatic apply_ref(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
        logic [4:0] cr;
        cr = ref_exec(op, ref_rf[ra], ref_rf[rb]);
        ref_rf[rd] = cr[3:0];
        ref_c = cr[4];
        ref_z = (cr[3:0] == 4'd0);
        ref_s = (cr[3:0] >= 4'd8);
    endtask

    task automatic check_reg(input string tag, input logic [2:0] idx, input logic [3:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic check_flags(input string tag);
        check(tag, {flag_z, flag_c, flag_s}, {ref_z, ref_c, ref_s});
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_alu_ab"}, {alu_a, alu_b}, 8'h00);
        check({tag, "_alu_opl"}, {alu_l, alu_op}, 3'd0);
        check({tag, "_flags"}, {flag_z, flag_c, flag_s}, 3'd0);
        for (int i = 0; i < 8; i++) check_reg({tag, "_rf"}, i[2:0], 4'd0);
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 8; i++) ref_rf[i] = 4'd0;
        ref_z = 1'b0; ref_c = 1'b0; ref_s = 1'b0;
    endtask

    task automatic load(input logic [2:0] a, input logic [3:0] d);
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        @(posedge clk);
        #1 bus.ld_valid = 1'b0;
        ref_rf[a] = d;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                             input logic [2:0] rb, input logic with_ld, input logic [2:0] la,
                             input logic [3:0] ld_d);
        logic [3:0] a, b;
        @(negedge clk);
        check("idle_ready", bus.instr_ready, 1'b1);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_ra    = ra;
        bus.instr_rb    = rb;
        bus.ld_valid    = with_ld;
        bus.ld_addr     = la;
        bus.ld_data     = ld_d;
        if (with_ld) ref_rf[la] = ld_d;
        a = ref_rf[ra];
        b = ref_rf[rb];
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.ld_valid    = 1'b0;
        check("read_busy", {bus.instr_ready, done}, 2'b00);
        @(posedge clk);
        #1;
        check("exec_operands", {alu_a, alu_b}, {a, b});
        check("exec_op", {alu_l, alu_op}, op);
        check("exec_no_done", done, 1'b0);
        @(posedge clk);
        #1;
        check("wb_done", {bus.instr_ready, done}, 2'b01);
        @(posedge clk);
        #1;
        apply_ref(op, rd, ra, rb);
        check("after_wb_done", done, 1'b0);
        check_flags("flags");
        check_reg("rd_value", rd, ref_rf[rd]);
    endtask

    initial begin
        int acc_cnt, done_cnt;
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_op    = 3'd0;
        bus.instr_rd    = 3'd0;
        bus.instr_ra    = 3'd0;
        bus.instr_rb    = 3'd0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = 3'd0;
        bus.ld_data     = 4'd0;
        dbg_addr        = 3'd0;
        clear_ref();

        // Power-up reset asserted mid-cycle
        #3 reset = 1'b0;
        #1 check_cleared("rst0");
        @(negedge clk) reset = 1'b1;
        #1 check("rst0_ready", bus.instr_ready, 1'b1);

        // Add 3+5
        load(3'd1, 4'd3);
        load(3'd2, 4'd5);
        run_instr(3'b010, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 4'd0);
        check_reg("add_r3_const", 3'd3, 4'd8);
        check("add_flags_const", {flag_z, flag_c, flag_s}, 3'b001);

        // Add with carry, aliased operands; then sub to zero
        load(3'd5, 4'd9);
        run_instr(3'b010, 3'd6, 3'd5, 3'd5, 1'b0, 3'd0, 4'd0);
        check_reg("add_r6_const", 3'd6, 4'd2);
        check("addc_flags_const", {flag_z, flag_c, flag_s}, 3'b010);
        run_instr(3'b011, 3'd4, 3'd2, 3'd2, 1'b0, 3'd0, 4'd0);
        check_reg("sub_r4_const", 3'd4, 4'd0);
        check("sub_flags_const", {flag_z, flag_c, flag_s}, 3'b110);

        // Negate, then negate with a same-cycle load of the source
        load(3'd1, 4'd1);
        run_instr(3'b000, 3'd7, 3'd1, 3'd0, 1'b0, 3'd0, 4'd0);
        check_reg("neg_r7_const", 3'd7, 4'hF);
        check("neg_flags_const", {flag_c, flag_s}, 2'b01);
        run_instr(3'b000, 3'd7, 3'd1, 3'd0, 1'b1, 3'd1, 4'd2);
        check_reg("neg_ld_r7_const", 3'd7, 4'hE);
        check_reg("neg_ld_r1", 3'd1, 4'd2);

        // Back-pressure: valid held for 12 cycles, loads attempted while busy
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'b010;
        bus.instr_rd    = 3'd3;
        bus.instr_ra    = 3'd3;
        bus.instr_rb    = 3'd1;
        bus.ld_addr     = 3'd3;
        bus.ld_data     = 4'hF;
        acc_cnt  = 0;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            check("bp_ready", bus.instr_ready, (k % 4 == 0));
            if (bus.instr_ready) acc_cnt++;
            if (done) done_cnt++;
            bus.ld_valid = (k % 4 != 0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        bus.ld_valid    = 1'b0;
        for (int j = 0; j < 3; j++) apply_ref(3'b010, 3'd3, 3'd3, 3'd1);
        check("bp_accepts", acc_cnt[7:0], 8'd3);
        check("bp_dones", done_cnt[7:0], 8'd3);
        check_reg("bp_r3", 3'd3, ref_rf[3]);
        check_flags("bp_flags");

        // Random instructions, some with a same-cycle load
        for (int n = 0; n < 24; n++) begin
            logic [2:0] op, rd, ra, rb, la;
            logic [3:0] ld_d;
            logic       wl;
            op   = 3'($urandom_range(0, 7));
            rd   = 3'($urandom_range(0, 7));
            ra   = 3'($urandom_range(0, 7));
            rb   = 3'($urandom_range(0, 7));
            la   = 3'($urandom_range(0, 7));
            ld_d = 4'($urandom_range(0, 15));
            wl   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) load(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            run_instr(op, rd, ra, rb, wl, la, ld_d);
        end
        for (int i = 0; i < 8; i++) check_reg("rand_rf", i[2:0], ref_rf[i]);

        // Mid-cycle reset while idle with live state
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_cleared("rst1");
        clear_ref();
        @(negedge clk) reset = 1'b1;
        #1 check("rst1_ready", bus.instr_ready, 1'b1);

        // Set flags, then abort an add to r3 during EXEC
        load(3'd1, 4'd3);
        load(3'd2, 4'd5);
        run_instr(3'b011, 3'd0, 3'd1, 3'd1, 1'b0, 3'd0, 4'd0);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'b010;
        bus.instr_rd    = 3'd3;
        bus.instr_ra    = 3'd1;
        bus.instr_rb    = 3'd2;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_cleared("rst_exec");
        clear_ref();
        @(negedge clk) reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("abort_ready", bus.instr_ready, 1'b1);
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", done_cnt[7:0], 8'd0);
        check_reg("abort_r3", 3'd3, 4'd0);

        // Controller still works after the abort
        load(3'd1, 4'd3);
        load(3'd2, 4'd5);
        run_instr(3'b010, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 4'd0);
        check_reg("post_abort_r3", 3'd3, 4'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
